// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_stage_buffer slice: occupancy state
// encoding, default widths and small state-decode helpers.
package pipe_pkg;

    // Default widths used when an instantiator does not override them.
    localparam int PS_DATA_W_DEF = 32;
    localparam int PS_CNT_W_DEF  = 16;

    // Occupancy of the stage: nothing held, main slot held, main + skid held.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_HALF  = 2'd1,
        PS_FULL  = 2'd2
    } ps_state_t;

    // True when the stage presents an entry downstream.
    function automatic logic ps_has_entry(input ps_state_t s);
        return (s != PS_EMPTY);
    endfunction

    // True when the stage still has a free slot (skid build only).
    function automatic logic ps_has_room(input ps_state_t s);
        return (s != PS_FULL);
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_stage_buffer_if.sv
// Valid/ready handshake bundle around one pipeline stage: the upstream
// (in_*) and downstream (out_*) sides travel together.
// slave  : the stage buffer's view.
// master : the surrounding pipeline's view (drives in_* and out_ready).
interface pipe_stage_buffer_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = PS_DATA_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface : pipe_stage_buffer_if

// File: rtl/pipe_stage_buffer_sat_counter.sv
// Saturating up-counter with synchronous clear. Holds at all-ones instead
// of wrapping so a long stall never reads back as a short one.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: step by one unless already at the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register; clear wins over increment.
    always_ff @(posedge Clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/pipe_stage_buffer.sv
// Reusable inter-stage register with valid/ready handshake, synchronous
// flush and a saturating stall counter.
// Build option: define PIPE_STAGE_SKID_EN to add a second (skid) slot so
// in_ready becomes a pure register decode with no path from out_ready.
// Without it the stage holds one entry and in_ready = out_ready | !out_valid.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int DATA_W     = PS_DATA_W_DEF,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = PS_CNT_W_DEF
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               flush,
    pipe_stage_buffer_if.slave bus,
    output logic [CNT_W-1:0]   stall_cnt
);

    ps_state_t         state_q;
    ps_state_t         state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic              out_valid_q;
    logic              in_ready_int;
    logic              accept;
    logic              emit;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              in_ready_q;

    // in_ready comes straight from a flop so upstream never sees out_ready.
    assign in_ready_int = in_ready_q;
`else
    // Single slot: room exists if empty or the held entry leaves this cycle.
    assign in_ready_int = bus.out_ready | ~out_valid_q;
`endif

    assign accept        = bus.in_valid & in_ready_int;
    assign emit          = out_valid_q & bus.out_ready;
    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;

    // Occupancy / payload next-state: flush first, then the handshake moves.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            // Squash everything; a same-cycle accept is dropped and a
            // same-cycle emit is simply considered consumed downstream.
            state_d = PS_EMPTY;
            if (CLEAR_DATA) begin
                main_d = '0;
`ifdef PIPE_STAGE_SKID_EN
                skid_d = '0;
`endif
            end
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    if (accept) begin
                        state_d = PS_HALF;
                        main_d  = bus.in_data;
                    end
                end
                PS_HALF: begin
                    if (accept && emit) begin
                        // Pass-through: the new entry replaces the departing one.
                        main_d = bus.in_data;
                    end else if (emit) begin
                        state_d = PS_EMPTY;
                    end else if (accept) begin
`ifdef PIPE_STAGE_SKID_EN
                        // Downstream stalled but upstream still pushed:
                        // park the newcomer behind the held entry.
                        state_d = PS_FULL;
                        skid_d  = bus.in_data;
`else
                        // Unreachable: in_ready is low whenever HALF and not
                        // emitting. Hold so nothing is overwritten.
                        state_d = PS_HALF;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                PS_FULL: begin
                    // in_ready is low here, so only the drain can happen.
                    if (emit) begin
                        state_d = PS_HALF;
                        main_d  = skid_q;
                    end
                end
`endif
                default: begin
                    state_d = PS_EMPTY;
                end
            endcase
        end
    end

    // State, payload and registered handshake outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= PS_EMPTY;
            out_valid_q <= 1'b0;
            if (CLEAR_DATA) begin
                main_q <= '0;
            end
        end else begin
            state_q     <= state_d;
            out_valid_q <= ps_has_entry(state_d);
            main_q      <= main_d;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    // Skid slot and the registered decode of "not FULL" used as in_ready.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            in_ready_q <= 1'b1;
            if (CLEAR_DATA) begin
                skid_q <= '0;
            end
        end else begin
            in_ready_q <= ps_has_room(state_d);
            skid_q     <= skid_d;
        end
    end
`endif

    // Stall cycles: valid data offered but not taken. Flush does not clear it.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .Clk (Clk),
        .clr (Rst),
        .inc (out_valid_q & ~bus.out_ready),
        .cnt (stall_cnt)
    );

endmodule : pipe_stage_buffer

// File: tb/tb_pipe_stage_buffer.sv
// Self-checking bench for pipe_stage_buffer (CLEAR_DATA=1, CNT_W=2).
// Table of directed vectors, hand-written multi-cycle sequences and a
// randomized run against a queue-based reference model.
module tb_pipe_stage_buffer;

    localparam int DW = 32;
    localparam int CW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [CW-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    pipe_stage_buffer_if #(.DATA_W(DW)) bus ();

    pipe_stage_buffer #(
        .DATA_W     (DW),
        .CLEAR_DATA (1'b1),
        .CNT_W      (CW)
    ) dut (
        .Clk       (clk),
        .Rst       (rst),
        .flush     (flush),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_last;
    int            m_cnt;

    function automatic logic m_in_ready(input logic ordy);
        if (CAP == 2) return (mq.size() < 2);
        return (ordy || mq.size() == 0);
    endfunction

    function automatic logic [DW-1:0] m_out_data();
        if (mq.size() > 0) return mq[0];
        return m_last;
    endfunction

    task automatic m_edge(input logic r, input logic f, input logic iv,
                          input logic [DW-1:0] d, input logic ordy);
        logic acc;
        logic emt;
        logic [DW-1:0] tmp;
        if (r) begin
            mq.delete();
            m_last = '0;
            m_cnt  = 0;
        end else begin
            if (mq.size() > 0 && !ordy && m_cnt < CNT_MAX) m_cnt++;
            acc = iv && m_in_ready(ordy);
            emt = (mq.size() > 0) && ordy;
            if (f) begin
                mq.delete();
                m_last = '0;
            end else begin
                if (emt) begin
                    tmp = mq.pop_front();
                    m_last = tmp;
                end
                if (acc) mq.push_back(d);
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [DW-1:0] d, input logic ordy);
        rst           = r;
        flush         = f;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [DW-1:0] od,
                           input logic rdy);
        chk({tag, ".out_valid"}, DW'(bus.out_valid), DW'(ov));
        chk({tag, ".out_data"},  bus.out_data, od);
        chk({tag, ".in_ready"},  DW'(bus.in_ready), DW'(rdy));
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic          r;
        logic          f;
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [CW-1:0] e_st;
        logic          e_rdy_skid;
        logic          e_rdy_base;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl[NV];

    initial begin
        logic          e_rdy;
        logic          iv_r, f_r, r_r, or_r;
        logic [DW-1:0] d_r;

        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);

        //          r     f     iv    d             ordy  ov    od            st    rdyS  rdyB
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        2'd0, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'hA5A50001, 1'b1, 1'b1, 32'hA5A50001, 2'd0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++)
            tbl[2+i] = '{1'b0, 1'b0, 1'b1, 32'(i+1), 1'b1, 1'b1, 32'(i+1), 2'd0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        2'd1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        2'd2, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        2'd3, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        2'd3, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        2'd3, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 32'h22,       1'b0, 1'b0, 32'h0,        2'd3, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        2'd3, 1'b1, 1'b1};
        tbl[17] = '{1'b1, 1'b1, 1'b1, 32'h33,       1'b1, 1'b0, 32'h0,        2'd0, 1'b1, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        2'd0, 1'b1, 1'b1};

        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            step();
`ifdef PIPE_STAGE_SKID_EN
            e_rdy = tbl[i].e_rdy_skid;
`else
            e_rdy = tbl[i].e_rdy_base;
`endif
            chk_out($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_od, e_rdy);
            chk($sformatf("vec%0d.stall_cnt", i), DW'(stall_cnt), DW'(tbl[i].e_st));
            $display("vec %0d: r=%0b f=%0b iv=%0b d=0x%08h ordy=%0b -> ov=%0b od=0x%08h rdy=%0b st=%0d",
                     i, tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].ordy,
                     bus.out_valid, bus.out_data, bus.in_ready, stall_cnt);
        end

`ifdef PIPE_STAGE_SKID_EN
        // Skid fill and drain: 0x10 held, 0x11 parked, then both in order.
        drive(1'b0, 1'b0, 1'b1, 32'h10, 1'b0); step();
        chk_out("skid.half", 1'b1, 32'h10, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h11, 1'b0); step();
        chk_out("skid.full", 1'b1, 32'h10, 1'b0);
        chk("skid.stall", DW'(stall_cnt), DW'(1));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); step();
        chk_out("skid.drain1", 1'b1, 32'h11, 1'b1);
        step();
        chk_out("skid.drain2", 1'b0, 32'h11, 1'b1);
        $display("seq skid fill/drain done");
        // Flush while FULL with a pending input that must vanish.
        drive(1'b0, 1'b0, 1'b1, 32'h20, 1'b0); step();
        drive(1'b0, 1'b0, 1'b1, 32'h21, 1'b0); step();
        chk_out("flushfull.pre", 1'b1, 32'h20, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 32'h22, 1'b1); step();
        chk_out("flushfull.post", 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out($sformatf("flushfull.idle%0d", k), 1'b0, 32'h0, 1'b1);
        end
        $display("seq flush in FULL done");
`else
        // Single slot: in_ready follows out_ready while holding an entry.
        drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b0); step();
        chk_out("base.half", 1'b1, 32'h40, 1'b0);
        bus.out_ready = 1'b1; #1;
        chk("base.rdy_comb", DW'(bus.in_ready), DW'(1));
        drive(1'b0, 1'b0, 1'b1, 32'h41, 1'b0); #1;
        chk("base.rdy_low", DW'(bus.in_ready), DW'(0));
        step();
        chk_out("base.blocked", 1'b1, 32'h40, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); step();
        chk_out("base.drain", 1'b0, 32'h40, 1'b1);
        $display("seq single-slot back-pressure done");
`endif

        // Randomized run against the reference model.
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        m_edge(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step();
        for (int n = 0; n < 3000; n++) begin
            r_r  = ($urandom_range(0, 149) == 0);
            f_r  = ($urandom_range(0, 24) == 0);
            iv_r = ($urandom_range(0, 9) < 7);
            or_r = ($urandom_range(0, 9) < 6);
            d_r  = $urandom;
            drive(r_r, f_r, iv_r, d_r, or_r);
            #1;
            chk($sformatf("rnd%0d.in_ready", n),  DW'(bus.in_ready),  DW'(m_in_ready(or_r)));
            chk($sformatf("rnd%0d.out_valid", n), DW'(bus.out_valid), DW'(mq.size() > 0));
            chk($sformatf("rnd%0d.out_data", n),  bus.out_data,       m_out_data());
            chk($sformatf("rnd%0d.stall_cnt", n), DW'(stall_cnt),     DW'(m_cnt));
            if (n % 250 == 0)
                $display("rnd %0d: ov=%0b od=0x%08h rdy=%0b st=%0d held=%0d",
                         n, bus.out_valid, bus.out_data, bus.in_ready, stall_cnt, mq.size());
            m_edge(r_r, f_r, iv_r, d_r, or_r);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_stage_buffer
